// File: rtl/div_arbiter_pkg.sv
// Shared types for the divider arbiter: requester id, result tag and default sizes.
package div_arbiter_pkg;

   localparam int unsigned DEF_TAMANYO = 32;
   localparam int unsigned DEF_N_REQ   = 4;
   localparam int unsigned N_REQ_MAX   = 8;
   localparam int unsigned ID_W        = $clog2(N_REQ_MAX);

   typedef logic [ID_W-1:0] req_id_t;

   typedef struct packed {
      logic    valid;
      req_id_t id;
      logic    dz;
   } tag_t;

endpackage

// File: rtl/Dividor_Segmentado.sv
// Fully pipelined signed restoring divider, one bit per stage; Start-to-Done latency tamanyo+1.
module Dividor_Segmentado #(
   parameter int unsigned tamanyo = 32
) (
   input  logic               CLK,
   input  logic               RSTa,
   input  logic               Start,
   input  logic [tamanyo-1:0] Num,
   input  logic [tamanyo-1:0] Den,
   output logic [tamanyo-1:0] Coc,
   output logic [tamanyo-1:0] Res,
   output logic               Done
);

   localparam int unsigned W = tamanyo;

   logic [W:0]   vld_q, vld_d;
   logic [W:0]   sq_q, sq_d;
   logic [W:0]   sr_q, sr_d;
   logic [W-1:0] rem_q [W+1];
   logic [W-1:0] rem_d [W+1];
   logic [W-1:0] quo_q [W+1];
   logic [W-1:0] quo_d [W+1];
   logic [W-1:0] dvs_q [W];
   logic [W-1:0] dvs_d [W];

   logic [W:0]   sh;
   logic [W:0]   diff;

   // Stage 0 takes magnitudes and signs; stages 1..W each resolve one quotient bit.
   always_comb begin
      sh       = '0;
      diff     = '0;
      vld_d[0] = Start;
      sq_d[0]  = Num[W-1] ^ Den[W-1];
      sr_d[0]  = Num[W-1];
      rem_d[0] = '0;
      quo_d[0] = Num[W-1] ? (W'(0) - Num) : Num;
      dvs_d[0] = Den[W-1] ? (W'(0) - Den) : Den;
      for (int k = 1; k < W; k++) begin
         dvs_d[k] = dvs_q[k-1];
      end
      for (int k = 1; k <= W; k++) begin
         vld_d[k] = vld_q[k-1];
         sq_d[k]  = sq_q[k-1];
         sr_d[k]  = sr_q[k-1];
         sh       = {rem_q[k-1], quo_q[k-1][W-1]};
         diff     = sh - {1'b0, dvs_q[k-1]};
         if (sh >= {1'b0, dvs_q[k-1]}) begin
            rem_d[k] = diff[W-1:0];
            quo_d[k] = {quo_q[k-1][W-2:0], 1'b1};
         end else begin
            rem_d[k] = sh[W-1:0];
            quo_d[k] = {quo_q[k-1][W-2:0], 1'b0};
         end
      end
      // Final stage only moves on a real result so the outputs hold between ops.
      if (!vld_q[W-1]) begin
         rem_d[W] = rem_q[W];
         quo_d[W] = quo_q[W];
         sq_d[W]  = sq_q[W];
         sr_d[W]  = sr_q[W];
      end
   end

   always_ff @(posedge CLK or negedge RSTa) begin
      if (!RSTa) begin
         vld_q <= '0;
         sq_q  <= '0;
         sr_q  <= '0;
         for (int k = 0; k <= W; k++) begin
            rem_q[k] <= '0;
            quo_q[k] <= '0;
         end
         for (int k = 0; k < W; k++) begin
            dvs_q[k] <= '0;
         end
      end else begin
         vld_q <= vld_d;
         sq_q  <= sq_d;
         sr_q  <= sr_d;
         for (int k = 0; k <= W; k++) begin
            rem_q[k] <= rem_d[k];
            quo_q[k] <= quo_d[k];
         end
         for (int k = 0; k < W; k++) begin
            dvs_q[k] <= dvs_d[k];
         end
      end
   end

   assign Coc  = sq_q[W] ? (W'(0) - quo_q[W]) : quo_q[W];
   assign Res  = sr_q[W] ? (W'(0) - rem_q[W]) : rem_q[W];
   assign Done = vld_q[W];

endmodule

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one pipelined divider among N_REQ requesters, with a tag pipe
// that routes each result back to its requester in grant order.
module div_arbiter
   import div_arbiter_pkg::*;
#(
   parameter int unsigned TAMANYO = DEF_TAMANYO,
   parameter int unsigned N_REQ   = DEF_N_REQ,
   parameter int unsigned LAT     = TAMANYO + 1
) (
   input  logic                     CLK,
   input  logic                     RSTa,
   input  logic                     Ena,
   input  logic [N_REQ-1:0]         Req,
   input  logic [N_REQ*TAMANYO-1:0] Num,
   input  logic [N_REQ*TAMANYO-1:0] Den,
   output logic [N_REQ-1:0]         Gnt,
   output logic [N_REQ-1:0]         Valid,
   output logic [TAMANYO-1:0]       Coc,
   output logic [TAMANYO-1:0]       Res,
   output logic                     DivZero,
   output logic                     Idle
);

   localparam int unsigned CNT_W = $clog2(LAT + 2);

   req_id_t            ptr_q, ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [TAMANYO-1:0] num_op_q, num_op_d;
   logic [TAMANYO-1:0] den_op_q, den_op_d;
   tag_t               op_tag_q, op_tag_d;
   tag_t               tag_q [LAT];
   tag_t               tag_d [LAT];

   logic               gnt_any;
   req_id_t            gnt_id;
   int unsigned        idx;
   logic [TAMANYO-1:0] sel_num;
   logic [TAMANYO-1:0] sel_den;
   tag_t               tail;
   logic               tail_vld;
   logic               div_done;

   // Rotating-priority search starting at the pointer.
   always_comb begin
      gnt_any = 1'b0;
      gnt_id  = '0;
      idx     = 0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         idx = (32'(ptr_q) + i) % N_REQ;
         if (!gnt_any && Ena && RSTa && Req[idx]) begin
            gnt_any = 1'b1;
            gnt_id  = req_id_t'(idx);
         end
      end
   end

   assign Gnt     = gnt_any ? (N_REQ'(1) << gnt_id) : '0;
   assign sel_num = Num[32'(gnt_id)*TAMANYO +: TAMANYO];
   assign sel_den = Den[32'(gnt_id)*TAMANYO +: TAMANYO];
   assign tail    = tag_q[LAT-1];
   assign tail_vld = tail.valid;

   always_comb begin
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      num_op_d = num_op_q;
      den_op_d = den_op_q;
      op_tag_d = '0;
      if (gnt_any) begin
         ptr_d          = (32'(gnt_id) == N_REQ - 1) ? '0 : gnt_id + req_id_t'(1);
         num_op_d       = sel_num;
         den_op_d       = sel_den;
         op_tag_d.valid = 1'b1;
         op_tag_d.id    = gnt_id;
         op_tag_d.dz    = (sel_den == '0);
      end
      if (gnt_any && !tail.valid) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (!gnt_any && tail.valid) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
      tag_d[0] = op_tag_q;
      for (int k = 1; k < LAT; k++) begin
         tag_d[k] = tag_q[k-1];
      end
   end

   always_ff @(posedge CLK or negedge RSTa) begin
      if (!RSTa) begin
         ptr_q    <= '0;
         cnt_q    <= '0;
         num_op_q <= '0;
         den_op_q <= '0;
         op_tag_q <= '0;
         for (int k = 0; k < LAT; k++) begin
            tag_q[k] <= '0;
         end
      end else begin
         ptr_q    <= ptr_d;
         cnt_q    <= cnt_d;
         num_op_q <= num_op_d;
         den_op_q <= den_op_d;
         op_tag_q <= op_tag_d;
         for (int k = 0; k < LAT; k++) begin
            tag_q[k] <= tag_d[k];
         end
      end
   end

   // Start is the registered grant: operands and tag enter the pipe together.
   Dividor_Segmentado #(
      .tamanyo (TAMANYO)
   ) u_div (
      .CLK   (CLK),
      .RSTa  (RSTa),
      .Start (op_tag_q.valid),
      .Num   (num_op_q),
      .Den   (den_op_q),
      .Coc   (Coc),
      .Res   (Res),
      .Done  (div_done)
   );

   assign Valid   = tail.valid ? (N_REQ'(1) << tail.id) : '0;
   assign DivZero = tail.valid & tail.dz;
   assign Idle    = (cnt_q == '0) && (Req == '0);

endmodule

// File: tb/tb_div_arbiter.sv
// Randomized and directed bench for div_arbiter against a queue-based behavioural model.
module tb_div_arbiter;

   localparam int W   = 32;
   localparam int N   = 4;
   localparam int LAT = W + 1;

   logic           CLK;
   logic           RSTa;
   logic           Ena;
   logic [N-1:0]   Req;
   logic [N*W-1:0] Num;
   logic [N*W-1:0] Den;
   logic [N-1:0]   Gnt;
   logic [N-1:0]   Valid;
   logic [W-1:0]   Coc;
   logic [W-1:0]   Res;
   logic           DivZero;
   logic           Idle;

   div_arbiter #(.TAMANYO(W), .N_REQ(N), .LAT(LAT)) dut (
      .CLK(CLK), .RSTa(RSTa), .Ena(Ena), .Req(Req), .Num(Num), .Den(Den),
      .Gnt(Gnt), .Valid(Valid), .Coc(Coc), .Res(Res), .DivZero(DivZero), .Idle(Idle)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      int         id;
      logic [W-1:0] num;
      logic [W-1:0] den;
      int         due;
   } exp_t;

   exp_t          q[$];
   int            mptr;
   int            cyc;
   logic [N-1:0]  mgnt;
   logic          have_last;
   logic [W-1:0]  last_coc;
   logic [W-1:0]  last_res;
   int            checks;
   int            failures;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Reference quotient/remainder: truncating signed division in 64-bit arithmetic.
   function automatic void model_div(input logic [W-1:0] n, input logic [W-1:0] d,
                                     output logic [W-1:0] qo, output logic [W-1:0] ro);
      longint ln, ld, lq, lr;
      ln = longint'($signed(n));
      ld = longint'($signed(d));
      lq = ln / ld;
      lr = ln % ld;
      qo = lq[W-1:0];
      ro = lr[W-1:0];
   endfunction

   function automatic int oh_id(input logic [N-1:0] v);
      int r;
      r = -1;
      for (int i = 0; i < N; i++) if (v[i]) r = i;
      return r;
   endfunction

   function automatic logic [W-1:0] rand_val();
      logic [W-1:0] v;
      case ($urandom_range(0, 5))
         0: v = W'($urandom);
         1: v = W'($urandom_range(0, 100)) - W'(50);
         2: v = 32'h8000_0000;
         3: v = 32'h7fff_ffff;
         4: v = 32'hffff_ffff;
         default: v = {{16{1'b0}}, 16'($urandom)} - 32'h0000_8000;
      endcase
      return v;
   endfunction

   // Per-cycle compare against the model: arbitration, result order, Idle and output hold.
   always @(negedge CLK) begin
      exp_t          e;
      int            gid;
      logic [N-1:0]  eg;
      logic          exp_idle;
      logic [W-1:0]  eq, er;
      if (!RSTa) begin
         q.delete();
         mptr      = 0;
         have_last = 1'b1;
         last_coc  = '0;
         last_res  = '0;
         mgnt      = '0;
         chk("rst_gnt", 64'(Gnt), 64'(0));
         chk("rst_valid", 64'(Valid), 64'(0));
         chk("rst_dz", 64'(DivZero), 64'(0));
         chk("rst_coc", 64'(Coc), 64'(0));
         chk("rst_res", 64'(Res), 64'(0));
         chk("rst_idle", 64'(Idle), 64'(Req == '0));
      end else begin
         exp_idle = (q.size() == 0) && (Req == '0);
         gid = -1;
         if (Ena) begin
            for (int i = 0; i < N; i++) begin
               if (gid < 0 && Req[(mptr + i) % N]) gid = (mptr + i) % N;
            end
         end
         eg = (gid >= 0) ? (N'(1) << gid) : '0;
         chk("gnt", 64'(Gnt), 64'(eg));
         chk("done_vs_tag", 64'(dut.div_done), 64'(dut.tail_vld));
         if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("valid", 64'(Valid), 64'(N'(1) << e.id));
            chk("divzero", 64'(DivZero), 64'(e.den == '0));
            if (e.den != '0) begin
               model_div(e.num, e.den, eq, er);
               chk("coc", 64'(Coc), 64'(eq));
               chk("res", 64'(Res), 64'(er));
               have_last = 1'b1;
               last_coc  = eq;
               last_res  = er;
            end else begin
               have_last = 1'b0;
            end
         end else begin
            chk("valid_idle", 64'(Valid), 64'(0));
            chk("divzero_idle", 64'(DivZero), 64'(0));
            if (have_last) begin
               chk("coc_hold", 64'(Coc), 64'(last_coc));
               chk("res_hold", 64'(Res), 64'(last_res));
            end
         end
         if (gid >= 0) begin
            e.id  = gid;
            e.num = Num[gid*W +: W];
            e.den = Den[gid*W +: W];
            e.due = cyc + 1 + LAT;
            q.push_back(e);
            mptr = (gid + 1) % N;
         end
         chk("idle", 64'(Idle), 64'(exp_idle));
         mgnt = eg;
      end
      cyc++;
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      tick();
      RSTa = 1'b0;
      Req  = '0;
      Ena  = 1'b1;
      repeat (3) tick();
      RSTa = 1'b1;
   endtask

   task automatic set_op(input int i, input logic [W-1:0] n, input logic [W-1:0] d);
      Num[i*W +: W] = n;
      Den[i*W +: W] = d;
   endtask

   // Single op from requester i; checks same-cycle grant and 34-cycle result latency.
   task automatic single_op(input int i, input logic [W-1:0] n, input logic [W-1:0] d,
                            input logic [W-1:0] ec, input logic [W-1:0] er);
      int n_cyc;
      logic seen;
      tick();
      Req = '0;
      Req[i] = 1'b1;
      set_op(i, n, d);
      @(negedge CLK);
      chk("single_gnt", 64'(Gnt), 64'(N'(1) << i));
      tick();
      Req = '0;
      n_cyc = 0;
      seen  = 1'b0;
      while (!seen && n_cyc < 60) begin
         @(negedge CLK);
         n_cyc++;
         if (Valid != '0) begin
            seen = 1'b1;
            chk("single_lat", 64'(n_cyc), 64'(LAT + 1));
            chk("single_vid", 64'(Valid), 64'(N'(1) << i));
            chk("single_coc", 64'(Coc), 64'(ec));
            chk("single_res", 64'(Res), 64'(er));
         end
      end
      if (!seen) chk("single_timeout", 64'(0), 64'(1));
   endtask

   initial begin
      logic [W-1:0] tq, tr;
      int           nv, vc;
      logic [N-1:0] ena_hold;
      checks = 0; failures = 0; cyc = 0; mptr = 0; mgnt = '0;
      have_last = 1'b1; last_coc = '0; last_res = '0;
      RSTa = 1'b0; Ena = 1'b1; Req = '0; Num = '0; Den = '0;
      ena_hold = '0;

      // Hand-computed anchors for the reference division.
      model_div(32'd100, 32'd7, tq, tr);
      chk("model_100_7_q", 64'(tq), 64'(32'd14));
      chk("model_100_7_r", 64'(tr), 64'(32'd2));
      model_div(-32'sd100, 32'd7, tq, tr);
      chk("model_m100_7_q", 64'(tq), 64'(32'hffff_fff2));
      chk("model_m100_7_r", 64'(tr), 64'(32'hffff_fffe));
      model_div(32'd100, -32'sd7, tq, tr);
      chk("model_100_m7_q", 64'(tq), 64'(32'hffff_fff2));
      chk("model_100_m7_r", 64'(tr), 64'(32'd2));

      repeat (3) tick();
      RSTa = 1'b1;

      single_op(0, 32'd100, 32'd7, 32'd14, 32'd2);
      single_op(1, -32'sd100, 32'd7, 32'hffff_fff2, 32'hffff_fffe);
      single_op(3, 32'd100, -32'sd7, 32'hffff_fff2, 32'd2);

      // All requesters held for 8 cycles from a fresh pointer.
      do_reset();
      for (int i = 0; i < N; i++) set_op(i, W'(1000 * (i + 1) + 17), W'(i + 3));
      Req = '1;
      for (int c = 0; c < 8; c++) begin
         @(negedge CLK);
         chk("rr_seq", 64'(oh_id(Gnt)), 64'(c % N));
         tick();
      end
      Req = '0;
      vc = 0;
      for (int c = 0; c < 60 && vc < 8; c++) begin
         @(negedge CLK);
         if (Valid != '0) begin
            chk("rr_valid_seq", 64'(oh_id(Valid)), 64'(vc % N));
            vc++;
         end
         tick();
      end
      chk("rr_valid_cnt", 64'(vc), 64'(8));

      // Divide by zero from requester 2 between neighbours.
      tick();
      set_op(1, 32'd55, 32'd5);
      set_op(2, 32'd77, 32'd0);
      set_op(3, -32'sd9, 32'd4);
      Req = 4'b1110;
      repeat (3) tick();
      Req = '0;
      nv = 0;
      for (int c = 0; c < 60 && nv < 3; c++) begin
         @(negedge CLK);
         if (Valid != '0) begin
            nv++;
            chk("dz_flag", 64'(DivZero), 64'(Valid[2]));
         end
         tick();
      end
      chk("dz_seen", 64'(nv), 64'(3));

      // Reset with ops in flight: nothing may come back afterwards.
      do_reset();
      Req[0] = 1'b1;
      set_op(0, 32'd1234, 32'd11);
      repeat (5) tick();
      Req = '0;
      repeat (4) tick();
      RSTa = 1'b0;
      repeat (2) tick();
      RSTa = 1'b1;
      nv = 0;
      for (int c = 0; c < 45; c++) begin
         @(negedge CLK);
         if (Valid != '0) nv++;
         tick();
      end
      chk("rst_no_valid", 64'(nv), 64'(0));
      @(negedge CLK);
      chk("rst_idle_after", 64'(Idle), 64'(1));
      single_op(2, 32'd100, 32'd7, 32'd14, 32'd2);

      // Enable low blocks grants while the request stays pending.
      tick();
      Ena = 1'b0;
      Req = 4'b0010;
      set_op(1, 32'd81, 32'd9);
      for (int c = 0; c < 20; c++) begin
         @(negedge CLK);
         chk("ena_low_gnt", 64'(Gnt), 64'(0));
         chk("ena_low_idle", 64'(Idle), 64'(0));
         tick();
      end
      Ena = 1'b1;
      @(negedge CLK);
      chk("ena_high_gnt", 64'(Gnt), 64'(4'b0010));
      tick();
      Req = '0;

      // Random traffic; requests stay up with fixed operands until granted.
      for (int c = 0; c < 3000; c++) begin
         tick();
         for (int i = 0; i < N; i++) begin
            if (!Req[i] || mgnt[i]) begin
               Req[i] = ($urandom_range(0, 99) < 55);
               set_op(i, rand_val(), ($urandom_range(0, 9) == 0) ? W'(0) : rand_val());
            end
         end
         if (Ena && $urandom_range(0, 29) == 0) Ena = 1'b0;
         else if (!Ena && $urandom_range(0, 3) == 0) Ena = 1'b1;
         if (c == 2500) begin
            RSTa = 1'b0;
            tick();
            RSTa = 1'b1;
         end
      end

      // Drain and confirm the block goes idle.
      tick();
      Req = '0;
      Ena = 1'b1;
      nv = 0;
      while (q.size() != 0 && nv < 100) begin
         tick();
         nv++;
      end
      chk("drain_done", 64'(q.size()), 64'(0));
      @(negedge CLK);
      chk("drain_idle", 64'(Idle), 64'(1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
